// File: rtl/axi_4_lite_mst.sv
// AXI4-Lite master: turns single-beat user commands into one outstanding AXI4-Lite
// write or read and returns the response status and read data to the user side.
//
// state     | meaning
// S_IDLE    | CMD_READY high, waiting for a user command
// S_WR      | AW and/or W handshake still pending
// S_WR_RESP | both write handshakes done, BREADY high
// S_RD_ADDR | ARVALID high, waiting for ARREADY
// S_RD_DATA | RREADY high, waiting for RVALID
module axi_4_lite_mst #(
  parameter int C_AXI_ADDR_WIDTH   = 32,
  parameter int C_AXI_DATA_WIDTH   = 32,
  parameter int C_AXI_STROBE_WIDTH = C_AXI_DATA_WIDTH / 8
) (
  input  logic                          M_AXI_ACLK,
  input  logic                          M_AXI_ARESETN,
  input  logic                          CMD_VALID,
  output logic                          CMD_READY,
  input  logic                          CMD_WRITE,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   CMD_ADDR,
  input  logic [C_AXI_DATA_WIDTH-1:0]   CMD_WDATA,
  input  logic [C_AXI_STROBE_WIDTH-1:0] CMD_WSTRB,
  output logic                          RSP_VALID,
  output logic [C_AXI_DATA_WIDTH-1:0]   RSP_RDATA,
  output logic [1:0]                    RSP_RESP,
  output logic                          RSP_ERR,
  output logic                          M_AXI_AWVALID,
  input  logic                          M_AXI_AWREADY,
  output logic [C_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                    M_AXI_AWPROT,
  output logic                          M_AXI_WVALID,
  input  logic                          M_AXI_WREADY,
  output logic [C_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_AXI_STROBE_WIDTH-1:0] M_AXI_WSTRB,
  input  logic                          M_AXI_BVALID,
  output logic                          M_AXI_BREADY,
  input  logic [1:0]                    M_AXI_BRESP,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  output logic [C_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                    M_AXI_ARPROT,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY,
  input  logic [C_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WR_RESP,
    S_RD_ADDR,
    S_RD_DATA
  } state_e;

  state_e                          state_q, state_d;
  logic                            cmd_ready_q, cmd_ready_d;
  logic                            awvalid_q, awvalid_d;
  logic                            wvalid_q, wvalid_d;
  logic                            bready_q, bready_d;
  logic                            arvalid_q, arvalid_d;
  logic                            rready_q, rready_d;
  logic [C_AXI_ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [C_AXI_DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [C_AXI_STROBE_WIDTH-1:0]   wstrb_q, wstrb_d;
  logic                            rsp_valid_q, rsp_valid_d;
  logic [C_AXI_DATA_WIDTH-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic [1:0]                      rsp_resp_q, rsp_resp_d;
  logic                            rsp_err_q, rsp_err_d;

  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b1;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      S_IDLE: begin
        if (CMD_VALID && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          addr_d      = CMD_ADDR;
          if (CMD_WRITE) begin
            wdata_d   = CMD_WDATA;
            wstrb_d   = CMD_WSTRB;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = S_RD_ADDR;
          end
        end
      end

      S_WR: begin
        // AW and W retire independently; either order or the same cycle.
        if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && M_AXI_WREADY)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = S_WR_RESP;
        end
      end

      S_WR_RESP: begin
        if (bready_q && M_AXI_BVALID) begin
          bready_d    = 1'b0;
          rsp_resp_d  = M_AXI_BRESP;
          rsp_err_d   = |M_AXI_BRESP;
          rsp_valid_d = 1'b1;
          cmd_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end

      S_RD_ADDR: begin
        if (arvalid_q && M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_DATA;
        end
      end

      S_RD_DATA: begin
        if (rready_q && M_AXI_RVALID) begin
          rready_d    = 1'b0;
          rsp_rdata_d = M_AXI_RDATA;
          rsp_resp_d  = M_AXI_RRESP;
          rsp_err_d   = |M_AXI_RRESP;
          rsp_valid_d = 1'b1;
          cmd_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d     = S_IDLE;
        cmd_ready_d = 1'b1;
        awvalid_d   = 1'b0;
        wvalid_d    = 1'b0;
        bready_d    = 1'b0;
        arvalid_d   = 1'b0;
        rready_d    = 1'b0;
      end
    endcase
  end

  // One address register serves both AW and AR; only one transaction is ever in flight.
  assign CMD_READY     = cmd_ready_q;
  assign RSP_VALID     = rsp_valid_q;
  assign RSP_RDATA     = rsp_rdata_q;
  assign RSP_RESP      = rsp_resp_q;
  assign RSP_ERR       = rsp_err_q;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi_4_lite_mst.sv
// Bench for axi_4_lite_mst: behavioural slave with programmable ready delays and
// error responses, reference memory model, and a response scoreboard.
module tb_axi_4_lite_mst;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        CMD_READY, RSP_VALID, RSP_ERR;
  logic [31:0] RSP_RDATA;
  logic [1:0]  RSP_RESP;
  logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic        M_AXI_RVALID, M_AXI_RREADY;
  logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
  logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;

  axi_4_lite_mst dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
    .CMD_VALID(cmd_valid), .CMD_READY(CMD_READY), .CMD_WRITE(cmd_write),
    .CMD_ADDR(cmd_addr), .CMD_WDATA(cmd_wdata), .CMD_WSTRB(cmd_wstrb),
    .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_RESP(RSP_RESP), .RSP_ERR(RSP_ERR),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_BRESP(M_AXI_BRESP),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // slave configuration
  int          aw_dly = 0, w_dly = 0, ar_dly = 0;
  logic [1:0]  b_err = 2'b00, r_err = 2'b00;

  // slave state
  logic [31:0] smem [16];
  int          aw_cnt, w_cnt, ar_cnt;
  logic        aw_have, w_have, ar_have;
  logic        aw_fire, w_fire, ar_fire, b_fire, r_fire;
  logic        aw_pv, w_pv, ar_pv;
  logic [31:0] aw_pa, ar_pa, w_pd, aw_l, ar_l, wd_l;
  logic [3:0]  w_ps, ws_l;

  always @(negedge clk) begin
    if (!rst_n) begin
      M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_ARREADY = 0;
      M_AXI_BVALID = 0; M_AXI_RVALID = 0; M_AXI_BRESP = 0; M_AXI_RRESP = 0; M_AXI_RDATA = 0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
      aw_have = 0; w_have = 0; ar_have = 0;
      aw_fire = 0; w_fire = 0; ar_fire = 0; b_fire = 0; r_fire = 0;
      aw_pv = 0; w_pv = 0; ar_pv = 0;
    end else begin
      // a VALID still waiting for its handshake must hold and keep its payload
      if (aw_pv && !aw_fire) chk("aw_hold", {M_AXI_AWVALID, M_AXI_AWADDR}, {1'b1, aw_pa});
      if (w_pv && !w_fire)
        chk("w_hold", {M_AXI_WVALID, M_AXI_WDATA, M_AXI_WSTRB}, {1'b1, w_pd, w_ps});
      if (ar_pv && !ar_fire) chk("ar_hold", {M_AXI_ARVALID, M_AXI_ARADDR}, {1'b1, ar_pa});
      if (M_AXI_BREADY) chk("bready_order", {M_AXI_AWVALID, M_AXI_WVALID}, 2'b00);

      if (aw_fire) begin aw_have = 1; aw_l = aw_pa; end
      if (w_fire)  begin w_have = 1; wd_l = w_pd; ws_l = w_ps; end
      if (ar_fire) begin ar_have = 1; ar_l = ar_pa; end
      if (b_fire) M_AXI_BVALID = 0;
      if (r_fire) M_AXI_RVALID = 0;

      if (aw_have && w_have && !M_AXI_BVALID) begin
        if (b_err == 2'b00)
          for (int i = 0; i < 4; i++)
            if (ws_l[i]) smem[aw_l[5:2]][8*i +: 8] = wd_l[8*i +: 8];
        M_AXI_BRESP = b_err; M_AXI_BVALID = 1; aw_have = 0; w_have = 0;
      end
      if (ar_have && !M_AXI_RVALID) begin
        M_AXI_RDATA = smem[ar_l[5:2]]; M_AXI_RRESP = r_err; M_AXI_RVALID = 1; ar_have = 0;
      end

      M_AXI_AWREADY = M_AXI_AWVALID && (aw_cnt >= aw_dly);
      aw_cnt = (M_AXI_AWVALID && !M_AXI_AWREADY) ? aw_cnt + 1 : 0;
      M_AXI_WREADY = M_AXI_WVALID && (w_cnt >= w_dly);
      w_cnt = (M_AXI_WVALID && !M_AXI_WREADY) ? w_cnt + 1 : 0;
      M_AXI_ARREADY = M_AXI_ARVALID && (ar_cnt >= ar_dly);
      ar_cnt = (M_AXI_ARVALID && !M_AXI_ARREADY) ? ar_cnt + 1 : 0;

      aw_pv = M_AXI_AWVALID; aw_pa = M_AXI_AWADDR; aw_fire = M_AXI_AWVALID && M_AXI_AWREADY;
      w_pv = M_AXI_WVALID; w_pd = M_AXI_WDATA; w_ps = M_AXI_WSTRB;
      w_fire = M_AXI_WVALID && M_AXI_WREADY;
      ar_pv = M_AXI_ARVALID; ar_pa = M_AXI_ARADDR; ar_fire = M_AXI_ARVALID && M_AXI_ARREADY;
      b_fire = M_AXI_BVALID && M_AXI_BREADY;
      r_fire = M_AXI_RVALID && M_AXI_RREADY;
    end
  end

  // reference model and scoreboard
  typedef struct { logic [31:0] rdata; logic [1:0] resp; } exp_t;
  exp_t        sb_q[$];
  logic [31:0] ref_mem [16];
  logic [31:0] last_rdata = '0;
  int          rsp_cnt = 0;

  always @(negedge clk) begin
    if (rst_n && RSP_VALID) begin
      exp_t e;
      rsp_cnt++;
      chk("rsp_expected", sb_q.size() > 0, 1'b1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("rsp_rdata", RSP_RDATA, e.rdata);
        chk("rsp_resp", RSP_RESP, e.resp);
        chk("rsp_err", RSP_ERR, |e.resp);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the command was accepted.
  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic expect_rsp_same_cycle);
    int   k = 0;
    exp_t e;
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    while (!CMD_READY && k < 300) begin @(negedge clk); k++; end
    chk("cmd_accept", CMD_READY, 1'b1);
    if (expect_rsp_same_cycle) chk("b2b_accept_on_rsp", RSP_VALID, 1'b1);
    if (wr) begin
      if (b_err == 2'b00)
        for (int i = 0; i < 4; i++)
          if (s[i]) ref_mem[a[5:2]][8*i +: 8] = d[8*i +: 8];
      e.rdata = last_rdata; e.resp = b_err;
    end else begin
      last_rdata = ref_mem[a[5:2]];
      e.rdata = last_rdata; e.resp = r_err;
    end
    sb_q.push_back(e);
    @(negedge clk);
    chk("busy_ready_low", CMD_READY, 1'b0);
  endtask

  task automatic wait_rsp(input int target, input string tag);
    int k = 0;
    while (rsp_cnt < target && k < 300) begin @(negedge clk); k++; end
    chk(tag, rsp_cnt >= target, 1'b1);
  endtask

  task automatic single(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input string tag);
    int n0 = rsp_cnt;
    issue(wr, a, d, s, 1'b0);
    cmd_valid = 0;
    wait_rsp(n0 + 1, tag);
    repeat (3) @(negedge clk);
    chk({tag, "_one_rsp"}, rsp_cnt, n0 + 1);
    chk({tag, "_idle"}, CMD_READY, 1'b1);
  endtask

  initial begin
    int n0;
    for (int i = 0; i < 16; i++) begin smem[i] = '0; ref_mem[i] = '0; end

    repeat (3) @(negedge clk);
    chk("rst_valids", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID,
                       M_AXI_RREADY, RSP_VALID}, 6'b0);
    chk("rst_rsp", {RSP_RDATA, RSP_RESP, RSP_ERR}, 35'b0);
    chk("rst_bus", {M_AXI_AWADDR, M_AXI_WDATA, M_AXI_WSTRB}, 68'b0);
    chk("prot", {M_AXI_AWPROT, M_AXI_ARPROT}, 6'b0);
    rst_n = 1;
    @(negedge clk);
    chk("rst_cmd_ready", CMD_READY, 1'b1);

    // basic write then read, then partial-strobe overwrite
    single(1, 32'h04, 32'hDEADBEEF, 4'hF, "wr_full");
    single(0, 32'h04, 32'h0, 4'h0, "rd_full");
    chk("rd_deadbeef", RSP_RDATA, 32'hDEADBEEF);
    single(1, 32'h04, 32'h11223344, 4'h5, "wr_strb");
    chk("wr_keeps_rdata", RSP_RDATA, 32'hDEADBEEF);
    single(0, 32'h04, 32'h0, 4'h0, "rd_strb");
    chk("rd_merge", RSP_RDATA, 32'hDE22BE44);

    // handshake ordering: AW late, W late, both together; read with AR delayed
    aw_dly = 3; w_dly = 0;
    single(1, 32'h20, 32'hA5A5_0001, 4'hF, "aw_late");
    aw_dly = 0; w_dly = 3;
    single(1, 32'h24, 32'hA5A5_0002, 4'hF, "w_late");
    aw_dly = 0; w_dly = 0;
    single(1, 32'h28, 32'hA5A5_0003, 4'hF, "same_cycle");
    ar_dly = 2;
    single(0, 32'h24, 32'h0, 4'h0, "ar_late");
    ar_dly = 0;

    // error responses
    b_err = 2'b10;
    single(1, 32'h10, 32'h5555_AAAA, 4'hF, "slverr_wr");
    chk("slverr_err", {RSP_ERR, RSP_RESP}, 3'b110);
    b_err = 2'b00; r_err = 2'b11;
    single(0, 32'h20, 32'h0, 4'h0, "decerr_rd");
    chk("decerr_err", {RSP_ERR, RSP_RESP}, 3'b111);
    r_err = 2'b00;
    single(0, 32'h28, 32'h0, 4'h0, "ok_after_err");
    chk("err_cleared", RSP_ERR, 1'b0);

    // CMD_VALID held high across alternating write/read commands
    n0 = rsp_cnt;
    issue(1, 32'h08, 32'h0BAD_F00D, 4'hF, 1'b0);
    issue(0, 32'h08, 32'h0, 4'h0, 1'b1);
    issue(1, 32'h0C, 32'h1357_9BDF, 4'hF, 1'b1);
    issue(0, 32'h0C, 32'h0, 4'h0, 1'b1);
    issue(1, 32'h08, 32'hFFFF_1234, 4'h3, 1'b1);
    issue(0, 32'h08, 32'h0, 4'h0, 1'b1);
    cmd_valid = 0;
    wait_rsp(n0 + 6, "b2b_done");
    repeat (3) @(negedge clk);
    chk("b2b_count", rsp_cnt, n0 + 6);
    chk("b2b_last", RSP_RDATA, 32'h0BAD_1234);

    // reset while WVALID is pending
    aw_dly = 20; w_dly = 20;
    issue(1, 32'h30, 32'h7777_7777, 4'hF, 1'b0);
    cmd_valid = 0;
    repeat (2) @(negedge clk);
    chk("wv_pending", M_AXI_WVALID, 1'b1);
    n0 = rsp_cnt;
    rst_n = 0;
    @(negedge clk);
    chk("mid_rst_valids", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID,
                           M_AXI_RREADY, RSP_VALID}, 6'b0);
    chk("mid_rst_rsp", {RSP_RDATA, RSP_RESP, RSP_ERR}, 35'b0);
    chk("mid_rst_bus", {M_AXI_AWADDR, M_AXI_WDATA, M_AXI_WSTRB}, 68'b0);
    chk("mid_rst_ready", CMD_READY, 1'b1);
    sb_q.delete();
    last_rdata = '0;
    aw_dly = 0; w_dly = 0;
    rst_n = 1;
    repeat (4) @(negedge clk);
    chk("no_rsp_after_rst", rsp_cnt, n0);
    single(1, 32'h14, 32'hCAFE_F00D, 4'hF, "post_rst_wr");
    single(0, 32'h14, 32'h0, 4'h0, "post_rst_rd");
    chk("post_rst_data", RSP_RDATA, 32'hCAFE_F00D);
    chk("sb_empty", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axi_4_lite_mst.md
Name: axi_4_lite_mst

Overview:
AXI4-Lite master (initiator) that turns single-beat commands from local user logic into AXI4-Lite write or read transactions. It drives the M_AXI_* channels toward a slave register file and returns read data and response status to the user side. One transaction is outstanding at a time. It is the bus-driving counterpart used by the team's bench and by on-chip controllers.

Parameters:
C_AXI_ADDR_WIDTH, 32, address width of AWADDR/ARADDR and CMD_ADDR
C_AXI_DATA_WIDTH, 32, data width; must be a multiple of 8
C_AXI_STROBE_WIDTH, C_AXI_DATA_WIDTH/8, byte-strobe width

Ports:
M_AXI_ACLK  in  1  single clock; all logic on rising edge
M_AXI_ARESETN  in  1  synchronous, active-low reset
CMD_VALID  in  1  user command valid
CMD_READY  out  1  master idle, command accepted on CMD_VALID&CMD_READY
CMD_WRITE  in  1  1 = write, 0 = read
CMD_ADDR  in  C_AXI_ADDR_WIDTH  byte address, passed through unmodified
CMD_WDATA  in  C_AXI_DATA_WIDTH  write data
CMD_WSTRB  in  C_AXI_STROBE_WIDTH  write byte strobes
RSP_VALID  out  1  one-cycle pulse: transaction complete
RSP_RDATA  out  C_AXI_DATA_WIDTH  read data of last read, held until next read completes
RSP_RESP  out  2  BRESP/RRESP of last transaction
RSP_ERR  out  1  RSP_RESP != OKAY (2'b00), valid with RSP_VALID
M_AXI_AWVALID/AWREADY  out/in  1  write address handshake
M_AXI_AWADDR  out  C_AXI_ADDR_WIDTH  write address
M_AXI_AWPROT  out  3  constant 3'b000
M_AXI_WVALID/WREADY  out/in  1  write data handshake
M_AXI_WDATA  out  C_AXI_DATA_WIDTH  write data
M_AXI_WSTRB  out  C_AXI_STROBE_WIDTH  write strobes
M_AXI_BVALID  in  1  write response valid
M_AXI_BREADY  out  1  write response ready
M_AXI_BRESP  in  2  write response
M_AXI_ARVALID/ARREADY  out/in  1  read address handshake
M_AXI_ARADDR  out  C_AXI_ADDR_WIDTH  read address
M_AXI_ARPROT  out  3  constant 3'b000
M_AXI_RVALID  in  1  read data valid
M_AXI_RREADY  out  1  read data ready
M_AXI_RDATA  in  C_AXI_DATA_WIDTH  read data
M_AXI_RRESP  in  2  read response

Behaviour:
- All outputs are registered. On reset: state IDLE, every *VALID/*READY driven to the bus = 0, CMD_READY = 1 after reset releases, RSP_VALID = 0, RSP_RDATA = 0, RSP_RESP = 0, RSP_ERR = 0, address/data/strobe outputs = 0.
- FSM states: IDLE, WR (AW and/or W pending), WR_RESP, RD_ADDR, RD_DATA.
- IDLE: CMD_READY = 1. Accept at edge N: latch address/data/strobe onto bus outputs. For a write, go to WR with AWVALID = WVALID = 1 from cycle N+1. For a read, go to RD_ADDR with ARVALID = 1 from N+1. CMD_READY = 0 in all other states. CMD_VALID outside IDLE is ignored.
- WR: AW and W are tracked independently. AWVALID drops the cycle after AWVALID&AWREADY, and WVALID drops the cycle after WVALID&WREADY. Handshakes may arrive in either order or in the same cycle. A VALID is never dropped before its handshake, and address/data stay stable while VALID is high. When both have completed, go to WR_RESP with BREADY = 1.
- WR_RESP: on BVALID&BREADY, drop BREADY, latch BRESP into RSP_RESP, pulse RSP_VALID the next cycle, and return to IDLE. CMD_READY = 1 in the same cycle as RSP_VALID, so back-to-back commands are allowed. A write leaves RSP_RDATA unchanged.
- RD_ADDR: on ARVALID&ARREADY, drop ARVALID, set RREADY = 1, go to RD_DATA.
- RD_DATA: on RVALID&RREADY, drop RREADY, latch RDATA and RRESP, pulse RSP_VALID the next cycle, return to IDLE.
- BVALID or RVALID arriving before the master's READY is held by the slave; the master ignores it until its READY is high.
- Non-OKAY response (SLVERR 2'b10, DECERR 2'b11): the transaction completes normally with RSP_ERR = 1 and no retry.
- Reset mid-transaction: all VALID/READY outputs are 0 on the next edge, state returns to IDLE, and no RSP_VALID is issued.
- No timeout. A slave that never responds stalls the master indefinitely, which is the intended behaviour.

Test Plan:
- Write 0xDEADBEEF to 0x04 with WSTRB 0xF, then read 0x04. Required: two RSP_VALID pulses, RSP_RDATA = 0xDEADBEEF, RSP_RESP = 0, RSP_ERR = 0.
- Write 0x11223344 with WSTRB 0x5 over 0xDEADBEEF, then read. Required: RSP_RDATA = 0xDE22BE44.
- Slave holds AWREADY low for 3 cycles while giving WREADY first, then the reverse order, then both in the same cycle. Required: each VALID stays high and stable until its own handshake; BREADY rises only after both handshakes; exactly one RSP_VALID.
- Slave returns BRESP = 2'b10, then RRESP = 2'b11. Required: RSP_ERR = 1 with RSP_RESP = 2'b10 and 2'b11 respectively, then FSM returns to IDLE.
- Hold CMD_VALID high continuously with alternating write/read commands. Required: a new command is accepted on each RSP_VALID cycle; CMD_VALID asserted while busy is ignored.
- Assert M_AXI_ARESETN = 0 while WVALID is pending. Required: all outputs at reset values on the next edge, no RSP_VALID, and a subsequent write completes normally.
